// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: measures a 0x55 sync byte on UartRx, drives BpsNum, supervises break/relock.
// Optional macro UART_AUTOBAUD_VERIFY_EN adds edge-to-edge interval checking during measurement.
module uart_autobaud_ctrl #(
  parameter int DEFAULT_BPS_NUM = 434,
  parameter int MIN_BPS_NUM     = 16,
  parameter int BREAK_MULT      = 16,
  parameter int CNT_W           = 24
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        UartRx,
  input  logic        relock,
  output logic [19:0] BpsNum,
  output logic        locked,
  output logic        lock_ok,
  output logic        err
);

  localparam int BRK_W = CNT_W + 5;

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    STOPWAIT,
    LOCKED,
    BRKWAIT
  } state_t;

  state_t             state_q, state_d;
  logic               rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         fidx_q, fidx_d;
  logic [19:0]        bnew_q, bnew_d;
  logic [20:0]        sw_cnt_q, sw_cnt_d;
  logic [BRK_W-1:0]   brk_cnt_q, brk_cnt_d;
  logic [19:0]        bps_q, bps_d;
  logic               locked_q, locked_d;
  logic               lock_ok_q, lock_ok_d;
  logic               err_q, err_d;

  logic               fall, rise;
  logic [CNT_W:0]     p_val;
  logic [19:0]        bnew_calc;
  logic [BRK_W-1:0]   brk_inc, brk_thr;
  logic               verr;

  assign fall      = rx_prev_q & ~rx_sync_q;
  assign rise      = ~rx_prev_q & rx_sync_q;
  // Elapsed cycles since the first falling edge, counting that edge's cycle as time 0.
  assign p_val     = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign bnew_calc = 20'(p_val >> 3);
  assign brk_inc   = (&brk_cnt_q) ? brk_cnt_q : brk_cnt_q + BRK_W'(1);
  assign brk_thr   = BRK_W'(BREAK_MULT) * BRK_W'(bps_q);

`ifdef UART_AUTOBAUD_VERIFY_EN
  logic [CNT_W:0]   ref_q, ref_d;
  logic             ref_vld_q, ref_vld_d;
  logic [CNT_W:0]   last_q, last_d;
  logic [CNT_W:0]   ival;
  logic [CNT_W+1:0] ival_x, ref_x, lo, hi;

  assign ival   = p_val - last_q;
  assign ival_x = {1'b0, ival};
  assign ref_x  = {1'b0, ref_q};
  assign lo     = ref_x - (ref_x >> 2);
  assign hi     = ref_x + (ref_x >> 2);

  always_comb begin
    ref_d     = ref_q;
    ref_vld_d = ref_vld_q;
    last_d    = last_q;
    verr      = 1'b0;
    if (state_q == IDLE) begin
      ref_vld_d = 1'b0;
      last_d    = '0;
    end else if (state_q == MEASURE) begin
      if (fall || rise) begin
        last_d = p_val;
        if (!ref_vld_q) begin
          ref_d     = ival;
          ref_vld_d = 1'b1;
        end else if (ival_x < lo || ival_x > hi) begin
          verr = 1'b1;
        end
      end else if (ref_vld_q && ival_x > hi) begin
        // A missing edge is caught as soon as the gap exceeds the upper bound.
        verr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_q     <= '0;
      ref_vld_q <= 1'b0;
      last_q    <= '0;
    end else begin
      ref_q     <= ref_d;
      ref_vld_q <= ref_vld_d;
      last_q    <= last_d;
    end
  end
`else
  assign verr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fidx_d    = fidx_q;
    bnew_d    = bnew_q;
    sw_cnt_d  = sw_cnt_q;
    brk_cnt_d = brk_cnt_q;
    bps_d     = bps_q;
    locked_d  = locked_q;
    lock_ok_d = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          cnt_d   = '0;
          fidx_d  = 3'd1;
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall) fidx_d = fidx_q + 3'd1;
        if (fall && fidx_q == 3'd4 && !verr) begin
          bnew_d   = bnew_calc;
          sw_cnt_d = '0;
          state_d  = STOPWAIT;
        end else if (verr || (&cnt_q)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      STOPWAIT: begin
        if (bnew_q < 20'(MIN_BPS_NUM)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          bps_d     = bnew_q;
          locked_d  = 1'b1;
          lock_ok_d = 1'b1;
          brk_cnt_d = '0;
          state_d   = LOCKED;
        end else if (sw_cnt_q >= {bnew_q, 1'b0}) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          sw_cnt_d = sw_cnt_q + 21'd1;
        end
      end

      LOCKED: begin
        if (!rx_sync_q) begin
          brk_cnt_d = brk_inc;
          if (brk_inc >= brk_thr) begin
            locked_d = 1'b0;
            state_d  = BRKWAIT;
          end
        end else begin
          brk_cnt_d = '0;
        end
      end

      BRKWAIT: begin
        if (rx_sync_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Relock overrides every event of the same cycle; the old rate stays in use.
    if (relock) begin
      state_d   = IDLE;
      locked_d  = 1'b0;
      lock_ok_d = 1'b0;
      err_d     = 1'b0;
      bps_d     = bps_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      fidx_q    <= '0;
      bnew_q    <= '0;
      sw_cnt_q  <= '0;
      brk_cnt_q <= '0;
      bps_q     <= 20'(DEFAULT_BPS_NUM);
      locked_q  <= 1'b0;
      lock_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= UartRx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fidx_q    <= fidx_d;
      bnew_q    <= bnew_d;
      sw_cnt_q  <= sw_cnt_d;
      brk_cnt_q <= brk_cnt_d;
      bps_q     <= bps_d;
      locked_q  <= locked_d;
      lock_ok_q <= lock_ok_d;
      err_q     <= err_d;
    end
  end

  assign BpsNum  = bps_q;
  assign locked  = locked_q;
  assign lock_ok = lock_ok_q;
  assign err     = err_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed plus randomized bench for uart_autobaud_ctrl with a rate-level reference model.
module tb_uart_autobaud_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        UartRx;
  logic        relock;
  logic [19:0] BpsNum;
  logic        locked;
  logic        lock_ok;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Pulse/stability monitor, sampled 2 time units after each active edge.
  int          n_ok = 0, n_err = 0, n_both = 0, n_glitch = 0;
  logic [19:0] bps_prev = 20'd434;

  // Reference model state, derived from the byte rate actually transmitted.
  logic [19:0] exp_bps    = 20'd434;
  logic        exp_locked = 1'b0;
  int          exp_ok     = 0;
  int          exp_err    = 0;

  uart_autobaud_ctrl dut (
    .clk     (clk),
    .rstn    (rstn),
    .UartRx  (UartRx),
    .relock  (relock),
    .BpsNum  (BpsNum),
    .locked  (locked),
    .lock_ok (lock_ok),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (rstn) begin
      if (lock_ok) n_ok++;
      if (err) n_err++;
      if (lock_ok && err) n_both++;
      if (BpsNum !== bps_prev && !lock_ok) n_glitch++;
    end
    bps_prev = BpsNum;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".bps"},    32'(BpsNum), 32'(exp_bps));
    chk({tag, ".locked"}, 32'(locked), 32'(exp_locked));
    chk({tag, ".n_ok"},   n_ok,        exp_ok);
    chk({tag, ".n_err"},  n_err,       exp_err);
  endtask

  // Start bit plus eight data bits, LSB first; called and returns at a negedge.
  task automatic send_frame(input logic [7:0] b, input int bt);
    UartRx = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UartRx = b[i];
      repeat (bt) @(negedge clk);
    end
  endtask

  // Full 0x55 sync byte at bt cycles/bit; the divisor is the 8-bit span divided by 8.
  task automatic do_sync(input int bt);
    int bnew;
    send_frame(8'h55, bt);
    UartRx = 1'b1;
    repeat (bt + 10) @(negedge clk);
    bnew = (8 * bt) / 8;
    if (bnew >= 16) begin
      exp_bps    = 20'(bnew);
      exp_locked = 1'b1;
      exp_ok++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    @(negedge clk);
    exp_locked = 1'b0;
  endtask

  initial begin
    int bt;
    rstn   = 1'b0;
    UartRx = 1'b1;
    relock = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.bps",     32'(BpsNum),  32'd434);
    chk("rst.locked",  32'(locked),  32'd0);
    chk("rst.lock_ok", 32'(lock_ok), 32'd0);
    chk("rst.err",     32'(err),     32'd0);
    rstn = 1'b1;
    repeat (1000) @(negedge clk);
    chk_state("idle1000");

    // First lock at 100 cycles/bit with exact lock_ok timing after the stop rise.
    send_frame(8'h55, 100);
    UartRx = 1'b1;
    @(negedge clk); chk("lk.pre1", 32'(lock_ok), 32'd0);
    @(negedge clk); chk("lk.pre2", 32'(lock_ok), 32'd0);
    @(negedge clk); chk("lk.pulse", 32'(lock_ok), 32'd1);
    chk("lk.bps", 32'(BpsNum), 32'd100);
    chk("lk.locked", 32'(locked), 32'd1);
    @(negedge clk); chk("lk.post", 32'(lock_ok), 32'd0);
    exp_bps = 20'd100; exp_locked = 1'b1; exp_ok++;
    repeat (96) @(negedge clk);

    // Ordinary traffic while locked is ignored.
    send_frame(8'hA3, 100);
    UartRx = 1'b1;
    repeat (300) @(negedge clk);
    chk_state("traffic");

    // Break: 16*100 consecutive low samples drop lock.
    UartRx = 1'b0;
    repeat (1601) @(negedge clk);
    chk("brk.before", 32'(locked), 32'd1);
    @(negedge clk);
    chk("brk.at", 32'(locked), 32'd0);
    exp_locked = 1'b0;
    UartRx = 1'b1;
    repeat (20) @(negedge clk);
    chk_state("brk.idle");
    do_sync(50);
    chk_state("relock50");

    // Divisor boundary around the minimum accepted value.
    pulse_relock();
    chk_state("rl.a");
    do_sync(15);
    chk_state("min15");
    do_sync(16);
    chk_state("min16");
    pulse_relock();
    do_sync(10);
    chk_state("min10");

    // Randomized rates, each preceded by a relock.
    for (int r = 0; r < 4; r++) begin
      bt = int'($urandom_range(17, 120));
      do_sync(bt);
      chk_state($sformatf("rnd%0d.bt%0d", r, bt));
      pulse_relock();
      chk_state($sformatf("rnd%0d.rl", r));
    end
    do_sync(70);
    chk_state("lock70");

    // Relock in the same cycle as the stop-bit rise of a new measurement.
    pulse_relock();
    send_frame(8'h55, 60);
    UartRx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    repeat (70) @(negedge clk);
    chk_state("rl.collide");
    do_sync(40);
    chk_state("after.collide");

    // 0xF0 is not a valid sync byte.
    pulse_relock();
    send_frame(8'hF0, 100);
    UartRx = 1'b1;
    repeat (1500) @(negedge clk);
`ifdef UART_AUTOBAUD_VERIFY_EN
    exp_err++;
`endif
    chk_state("f0");
    pulse_relock();
    do_sync(30);
    chk_state("lock30");

    // Asynchronous reset in the middle of a measurement.
    pulse_relock();
    UartRx = 1'b0;
    repeat (40) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("amid.bps",    32'(BpsNum), 32'd434);
    chk("amid.locked", 32'(locked), 32'd0);
    UartRx = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    chk("pulse.overlap", n_both,   0);
    chk("bps.glitch",    n_glitch, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
